// File: rtl/board_input_conditioner_pkg.sv
// Shared definitions for the board input conditioner: debounce FSM encodings and
// millisecond-to-cycle conversion (clamped to at least one cycle).
package board_input_conditioner_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } debounce_state_e;

    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz, input int unsigned ms);
        int unsigned cycles;
        cycles = freq_hz / 1000 * ms;
        return (cycles < 32'd1) ? 32'd1 : cycles;
    endfunction

endpackage

// File: rtl/board_input_conditioner_channel.sv
// One input channel: 2-flop synchroniser, counter debounce FSM, registered edge pulses and,
// with BOARD_INPUT_LONG_PRESS_EN defined, a saturating hold counter driving long_press.
module input_debounce_channel
    import board_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1,
    parameter int unsigned LONG_PRESS_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_level,
    output logic debounced,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic long_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    debounce_state_e  state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             accept;

    assign s = sync_q[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q     <= 2'b00;
            state      <= STABLE;
            count      <= '0;
            debounced  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], raw_level};
            state      <= state_next;
            count      <= count_next;
            debounced  <= accept ? s : debounced;
            rise_pulse <= accept & s;
            fall_pulse <= accept & ~s;
        end
    end

    // The cycle that first sees the difference counts as the first stable cycle,
    // which makes a clean edge land exactly DEBOUNCE_CYCLES clocks after synchronisation.
    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        case (state)
            STABLE: begin
                count_next = '0;
                if (s != debounced) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_next = PENDING;
                        count_next = CNT_W'(1);
                    end
                end
            end
            PENDING: begin
                if (s == debounced) begin
                    state_next = STABLE;
                    count_next = '0;
                end else if (count == COUNT_LAST) begin
                    state_next = STABLE;
                    count_next = '0;
                    accept     = 1'b1;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: begin
                state_next = STABLE;
                count_next = '0;
            end
        endcase
    end

`ifdef BOARD_INPUT_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold_count;

    // Saturates at HOLD_LAST so the pulse fires once per press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_count <= '0;
            long_press <= 1'b0;
        end else if (!debounced) begin
            hold_count <= '0;
            long_press <= 1'b0;
        end else if (hold_count != HOLD_LAST) begin
            hold_count <= hold_count + HOLD_W'(1);
            long_press <= (hold_count == HOLD_LAST - HOLD_W'(1));
        end else begin
            long_press <= 1'b0;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/board_input_conditioner.sv
// Board input conditioner top: per-channel debounce plus a stretched active-high system reset.
// Optional long-press detection is built when BOARD_INPUT_LONG_PRESS_EN is defined.
module board_input_conditioner
    import board_input_conditioner_pkg::*;
#(
    parameter int unsigned NUM_INPUTS           = 4,
    parameter int unsigned CLOCK_FREQUENCY      = 12000000,
    parameter int unsigned DEBOUNCE_MS          = 10,
    parameter int unsigned RESET_INPUT_INDEX    = 0,
    parameter int unsigned RESET_STRETCH_CYCLES = 16,
    parameter int unsigned LONG_PRESS_MS        = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] raw_input,
    output logic [NUM_INPUTS-1:0] debounced,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse,
    output logic [NUM_INPUTS-1:0] long_press,
    output logic                  system_reset
);

    localparam int unsigned DEBOUNCE_CYCLES   = ms_to_cycles(CLOCK_FREQUENCY, DEBOUNCE_MS);
    localparam int unsigned LONG_PRESS_CYCLES = ms_to_cycles(CLOCK_FREQUENCY, LONG_PRESS_MS);
    localparam int unsigned STRETCH_W         = $clog2(RESET_STRETCH_CYCLES + 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(RESET_STRETCH_CYCLES);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_channel
        input_debounce_channel #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_channel (
            .clock      (clock),
            .reset      (reset),
            .raw_level  (raw_input[i]),
            .debounced  (debounced[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .long_press (long_press[i])
        );
    end

    logic [STRETCH_W-1:0] stretch_count;
    logic                 stretch_active;
    logic                 reset_request;

    assign reset_request = debounced[RESET_INPUT_INDEX];

    // Reloads while the reset button is held, so a re-press during the tail never opens a gap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stretch_count  <= STRETCH_LOAD;
            stretch_active <= 1'b1;
        end else if (reset_request) begin
            stretch_count  <= STRETCH_LOAD;
            stretch_active <= 1'b1;
        end else if (stretch_count > STRETCH_W'(1)) begin
            stretch_count  <= stretch_count - STRETCH_W'(1);
            stretch_active <= 1'b1;
        end else begin
            stretch_count  <= '0;
            stretch_active <= 1'b0;
        end
    end

    assign system_reset = stretch_active | reset_request;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner with an expected-vector queue checked every cycle.
module tb_board_input_conditioner;

    localparam int W = 17;
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] C0   = 4'b0001;
    localparam logic [3:0] C1   = 4'b0010;
    localparam logic [3:0] C2   = 4'b0100;
    localparam logic [3:0] C3   = 4'b1000;
    localparam logic [3:0] ALL  = 4'b1111;
`ifdef BOARD_INPUT_LONG_PRESS_EN
    localparam logic [3:0] LP0 = 4'b0001;
    localparam logic [3:0] LP3 = 4'b1000;
`else
    localparam logic [3:0] LP0 = 4'b0000;
    localparam logic [3:0] LP3 = 4'b0000;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] raw_input;
    logic [3:0] debounced;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] long_press;
    logic       system_reset;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [W-1:0] exp_q[$];

    board_input_conditioner #(
        .NUM_INPUTS           (4),
        .CLOCK_FREQUENCY      (1000),
        .DEBOUNCE_MS          (8),
        .RESET_INPUT_INDEX    (0),
        .RESET_STRETCH_CYCLES (4),
        .LONG_PRESS_MS        (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .raw_input    (raw_input),
        .debounced    (debounced),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .long_press   (long_press),
        .system_reset (system_reset)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] mk(input logic sys, input logic [3:0] lp, input logic [3:0] fall,
                                        input logic [3:0] rise, input logic [3:0] deb);
        return {sys, lp, fall, rise, deb};
    endfunction

    task automatic push(input int n, input logic [W-1:0] v);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic check_now(input string tag);
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        obs = {system_reset, long_press, fall_pulse, rise_pulse, debounced};
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) passes++;
            else begin
                fails++;
                $error("FAIL %s: observed %h expected %h (sys|lp|fall|rise|deb)", tag, obs, exp);
            end
        end
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            check_now(tag);
        end
    endtask

    initial begin
        logic [W-1:0] z;
        z = mk(1'b0, NONE, NONE, NONE, NONE);
        raw_input = 4'b0000;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        push(1, mk(1'b1, NONE, NONE, NONE, NONE));
        check_now("reset_state");

        // Power-on: reset held 3 clocks, then a 4-clock stretch.
        repeat (3) @(negedge clock);
        reset = 1'b1;
        push(3, mk(1'b1, NONE, NONE, NONE, NONE));
        push(3, z);
        run(6, "power_on_stretch");

        // Clean edge on channel 1.
        raw_input[1] = 1'b1;
        push(9, z);
        push(1, mk(1'b0, NONE, NONE, C1, C1));
        push(2, mk(1'b0, NONE, NONE, NONE, C1));
        run(12, "ch1_rise");
        raw_input[1] = 1'b0;
        push(9, mk(1'b0, NONE, NONE, NONE, C1));
        push(1, mk(1'b0, NONE, C1, NONE, NONE));
        push(2, z);
        run(12, "ch1_fall");

        // Five-clock glitch on channel 2 is rejected.
        raw_input[2] = 1'b1;
        push(5, z);
        run(5, "ch2_glitch_high");
        raw_input[2] = 1'b0;
        push(12, z);
        run(12, "ch2_glitch_low");

        // Reset button: press, short release bounce, hold, release with stretch.
        raw_input[0] = 1'b1;
        push(9, z);
        push(1, mk(1'b1, NONE, NONE, C0, C0));
        push(10, mk(1'b1, NONE, NONE, NONE, C0));
        run(20, "ch0_press");
        raw_input[0] = 1'b0;
        push(3, mk(1'b1, NONE, NONE, NONE, C0));
        run(3, "ch0_bounce");
        raw_input[0] = 1'b1;
        push(12, mk(1'b1, NONE, NONE, NONE, C0));
        run(12, "ch0_repress");
        raw_input[0] = 1'b0;
        push(6, mk(1'b1, NONE, NONE, NONE, C0));
        push(1, mk(1'b1, LP0, NONE, NONE, C0));
        push(2, mk(1'b1, NONE, NONE, NONE, C0));
        push(1, mk(1'b1, NONE, C0, NONE, NONE));
        push(3, mk(1'b1, NONE, NONE, NONE, NONE));
        push(3, z);
        run(16, "ch0_release_stretch");

        // All channels change on the same clock.
        raw_input = ALL;
        push(9, z);
        push(1, mk(1'b1, NONE, NONE, ALL, ALL));
        push(2, mk(1'b1, NONE, NONE, NONE, ALL));
        run(12, "all_rise");
        raw_input = NONE;
        push(9, mk(1'b1, NONE, NONE, NONE, ALL));
        push(1, mk(1'b1, NONE, ALL, NONE, NONE));
        push(3, mk(1'b1, NONE, NONE, NONE, NONE));
        push(2, z);
        run(15, "all_fall");

        // Long hold on channel 3.
        raw_input[3] = 1'b1;
        push(9, z);
        push(1, mk(1'b0, NONE, NONE, C3, C3));
        push(31, mk(1'b0, NONE, NONE, NONE, C3));
        push(1, mk(1'b0, LP3, NONE, NONE, C3));
        push(8, mk(1'b0, NONE, NONE, NONE, C3));
        run(50, "ch3_long_hold");
        raw_input[3] = 1'b0;
        push(9, mk(1'b0, NONE, NONE, NONE, C3));
        push(1, mk(1'b0, NONE, C3, NONE, NONE));
        push(2, z);
        run(12, "ch3_release");

        // Reset in the middle of a pending debounce; the pin is still high afterwards.
        raw_input[2] = 1'b1;
        push(5, z);
        run(5, "ch2_pending");
        reset = 1'b0;
        #1;
        push(1, mk(1'b1, NONE, NONE, NONE, NONE));
        check_now("reset_async_assert");
        @(negedge clock);
        push(1, mk(1'b1, NONE, NONE, NONE, NONE));
        check_now("reset_held");
        reset = 1'b1;
        push(3, mk(1'b1, NONE, NONE, NONE, NONE));
        push(6, z);
        push(1, mk(1'b0, NONE, NONE, C2, C2));
        push(2, mk(1'b0, NONE, NONE, NONE, C2));
        run(12, "post_reset_accept");
        raw_input[2] = 1'b0;
        push(9, mk(1'b0, NONE, NONE, NONE, C2));
        push(1, mk(1'b0, NONE, C2, NONE, NONE));
        push(1, z);
        run(11, "ch2_fall");

        checks++;
        assert (exp_q.size() == 0) passes++;
        else begin
            fails++;
            $error("FAIL queue_drained: observed %0d expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
